execution_stage: RTL and testbench
==================================

Name: execution_stage

Overview:
- Execute stage of a 5-stage RV32I in-order pipeline, between decode and memory.
- Selects the ALU operands, performs the ALU or branch-compare operation, and registers the result and forwarded control fields into the EX/MEM pipeline register.
- Supports a stall that holds the register contents.

Parameters:
- None. All widths are fixed: data 32, register address 5, ALU opcode 5.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous active-high reset
- STALL_EXECUTION_STAGE  in  1  hold all output registers
- PC_IN  in  32  PC of the instruction in EX
- RD_ADDRESS_IN  in  5  destination register
- RS1_DATA  in  32  source operand 1
- RS2_DATA  in  32  source operand 2
- IMM_DATA  in  32  sign-extended immediate
- ALU_INSTRUCTION  in  5  ALU opcode (see Behaviour)
- ALU_INPUT_1_SELECT  in  1  operand A: 0 = RS1_DATA, 1 = PC_IN
- ALU_INPUT_2_SELECT  in  1  operand B: 0 = RS2_DATA, 1 = IMM_DATA
- DATA_CACHE_LOAD_IN  in  3  load type, passed through
- DATA_CACHE_STORE_IN  in  2  store type, passed through
- DATA_CACHE_STORE_DATA_IN  in  32  store data, passed through
- WRITE_BACK_MUX_SELECT_IN  in  1  writeback source, passed through
- RD_WRITE_ENABLE_IN  in  1  register-file write enable, passed through
- RD_ADDRESS_OUT  out  5  registered RD_ADDRESS_IN
- ALU_OUT  out  32  registered ALU result
- BRANCH_TAKEN  out  1  registered branch/jump decision
- DATA_CACHE_LOAD_OUT  out  3  registered copy of DATA_CACHE_LOAD_IN
- DATA_CACHE_STORE_OUT  out  2  registered copy of DATA_CACHE_STORE_IN
- DATA_CACHE_STORE_DATA_OUT  out  32  registered copy of DATA_CACHE_STORE_DATA_IN
- WRITE_BACK_MUX_SELECT_OUT  out  1  registered copy of WRITE_BACK_MUX_SELECT_IN
- RD_WRITE_ENABLE_OUT  out  1  registered copy of RD_WRITE_ENABLE_IN

Behaviour:
- One clock domain (CLK). Reset is asynchronous and active-high (RST).
- Reset: every output register is 0 immediately on RST assertion. RST has priority over stall and clock.
- Latency: 1 cycle. Inputs sampled at rising edge N appear on outputs after edge N.
- Stall: when STALL_EXECUTION_STAGE=1 at an edge, all output registers keep their values. Inputs are ignored for that edge.
- Operand mux: A = ALU_INPUT_1_SELECT ? PC_IN : RS1_DATA; B = ALU_INPUT_2_SELECT ? IMM_DATA : RS2_DATA.
- Arithmetic is 32-bit modulo 2^32. No overflow flags. Shift amount is B[4:0].
- ALU_INSTRUCTION encoding (result -> ALU_OUT):
  - 00001 ADD A+B
  - 00010 SUB A-B
  - 00011 SLL A<<B[4:0]
  - 00100 SLT signed(A<B) ? 1 : 0
  - 00101 SLTU unsigned(A<B) ? 1 : 0
  - 00110 XOR
  - 00111 SRL logical right shift
  - 01000 SRA arithmetic right shift
  - 01001 OR
  - 01010 AND
  - 10001 PASSB: ALU_OUT = B (for LUI)
- Branch opcodes compare RS1_DATA with RS2_DATA directly, regardless of the operand selects. ALU_OUT = 0 and BRANCH_TAKEN = comparison result:
  - 01011 BEQ
  - 01100 BNE
  - 01101 BLT (signed)
  - 01110 BGE (signed)
  - 01111 BLTU (unsigned)
  - 10000 BGEU (unsigned)
- 10010 JUMP (JAL/JALR link): ALU_OUT = PC_IN + 4, BRANCH_TAKEN = 1. Target address is computed outside this block.
- For all non-branch, non-jump opcodes BRANCH_TAKEN = 0.
- 00000 and unlisted codes (10011-11111): ALU_OUT = 0, BRANCH_TAKEN = 0.
- Pass-through fields are registered unchanged, with no qualification by opcode.
- Stall and reset asserted together: reset wins; outputs are 0.

Test Plan:
- Reset: assert RST mid-cycle with nonzero outputs -> all outputs 0 immediately, without waiting for a clock edge; outputs stay 0 while RST=1.
- ADD register-register: RS1=2, RS2=1, opcode 00001, selects 0/0, one edge -> ALU_OUT=3, BRANCH_TAKEN=0. Also RS1=0xFFFFFFFF, RS2=1 -> ALU_OUT=0 (wrap-around).
- Operand selects and shifts: PC_IN=0x100, IMM=0x20, selects 1/1, ADD -> 0x120. RS1=0x80000000, IMM=4, select2=1: SRA -> 0xF8000000, SRL -> 0x08000000. SLT with RS1=-1, RS2=1 -> 1; SLTU with the same operands -> 0.
- Branches: RS1=0xFFFFFFFF, RS2=1 -> BLT=0? no: BLT taken=1, BLTU=0, BGEU=1, BNE=1, BEQ=0; ALU_OUT=0 for each.
- JUMP: PC_IN=0x40, opcode 10010 -> ALU_OUT=0x44, BRANCH_TAKEN=1.
- Stall and pass-through: load RD=5, LOAD=3'b010, STORE=2'b01, STORE_DATA=0xDEADBEEF, WB=1, WE=1 -> all appear after 1 edge. Raise stall, change every input, clock 3 edges -> outputs unchanged. Drop stall -> new values after the next edge.

Source files
------------

// File: rtl/execution_stage_if.sv
// execution_stage_if: decode-to-EX inputs and EX/MEM register outputs of the execute stage
interface execution_stage_if;
  logic        STALL_EXECUTION_STAGE;
  logic [31:0] PC_IN;
  logic [4:0]  RD_ADDRESS_IN;
  logic [31:0] RS1_DATA;
  logic [31:0] RS2_DATA;
  logic [31:0] IMM_DATA;
  logic [4:0]  ALU_INSTRUCTION;
  logic        ALU_INPUT_1_SELECT;
  logic        ALU_INPUT_2_SELECT;
  logic [2:0]  DATA_CACHE_LOAD_IN;
  logic [1:0]  DATA_CACHE_STORE_IN;
  logic [31:0] DATA_CACHE_STORE_DATA_IN;
  logic        WRITE_BACK_MUX_SELECT_IN;
  logic        RD_WRITE_ENABLE_IN;
  logic [4:0]  RD_ADDRESS_OUT;
  logic [31:0] ALU_OUT;
  logic        BRANCH_TAKEN;
  logic [2:0]  DATA_CACHE_LOAD_OUT;
  logic [1:0]  DATA_CACHE_STORE_OUT;
  logic [31:0] DATA_CACHE_STORE_DATA_OUT;
  logic        WRITE_BACK_MUX_SELECT_OUT;
  logic        RD_WRITE_ENABLE_OUT;
  modport master (
    output STALL_EXECUTION_STAGE, PC_IN, RD_ADDRESS_IN, RS1_DATA, RS2_DATA, IMM_DATA,
           ALU_INSTRUCTION, ALU_INPUT_1_SELECT, ALU_INPUT_2_SELECT, DATA_CACHE_LOAD_IN,
           DATA_CACHE_STORE_IN, DATA_CACHE_STORE_DATA_IN, WRITE_BACK_MUX_SELECT_IN,
           RD_WRITE_ENABLE_IN,
    input  RD_ADDRESS_OUT, ALU_OUT, BRANCH_TAKEN, DATA_CACHE_LOAD_OUT, DATA_CACHE_STORE_OUT,
           DATA_CACHE_STORE_DATA_OUT, WRITE_BACK_MUX_SELECT_OUT, RD_WRITE_ENABLE_OUT
  );
  modport slave (
    input  STALL_EXECUTION_STAGE, PC_IN, RD_ADDRESS_IN, RS1_DATA, RS2_DATA, IMM_DATA,
           ALU_INSTRUCTION, ALU_INPUT_1_SELECT, ALU_INPUT_2_SELECT, DATA_CACHE_LOAD_IN,
           DATA_CACHE_STORE_IN, DATA_CACHE_STORE_DATA_IN, WRITE_BACK_MUX_SELECT_IN,
           RD_WRITE_ENABLE_IN,
    output RD_ADDRESS_OUT, ALU_OUT, BRANCH_TAKEN, DATA_CACHE_LOAD_OUT, DATA_CACHE_STORE_OUT,
           DATA_CACHE_STORE_DATA_OUT, WRITE_BACK_MUX_SELECT_OUT, RD_WRITE_ENABLE_OUT
  );
endinterface

// File: rtl/execution_stage.sv
// execution_stage: RV32I execute stage, ALU/branch compare into a stallable EX/MEM register
module execution_stage (
  input  logic CLK,
  input  logic RST,
  execution_stage_if.slave bus
);
  logic [31:0] w_a, w_b, w_alu;
  logic        w_br;
  logic [4:0]  r_rd;
  logic [31:0] r_alu, r_sd;
  logic        r_br, r_wb, r_we;
  logic [2:0]  r_ld;
  logic [1:0]  r_st;
  assign w_a = bus.ALU_INPUT_1_SELECT ? bus.PC_IN : bus.RS1_DATA;
  assign w_b = bus.ALU_INPUT_2_SELECT ? bus.IMM_DATA : bus.RS2_DATA;
  // branch compares use the raw register operands, never the muxed A/B
  always_comb begin
    w_alu = '0;
    w_br  = 1'b0;
    case (bus.ALU_INSTRUCTION)
      5'b00001: w_alu = w_a + w_b;
      5'b00010: w_alu = w_a - w_b;
      5'b00011: w_alu = w_a << w_b[4:0];
      5'b00100: w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
      5'b00101: w_alu = {31'd0, w_a < w_b};
      5'b00110: w_alu = w_a ^ w_b;
      5'b00111: w_alu = w_a >> w_b[4:0];
      5'b01000: w_alu = $signed(w_a) >>> w_b[4:0];
      5'b01001: w_alu = w_a | w_b;
      5'b01010: w_alu = w_a & w_b;
      5'b01011: w_br  = bus.RS1_DATA == bus.RS2_DATA;
      5'b01100: w_br  = bus.RS1_DATA != bus.RS2_DATA;
      5'b01101: w_br  = $signed(bus.RS1_DATA) < $signed(bus.RS2_DATA);
      5'b01110: w_br  = $signed(bus.RS1_DATA) >= $signed(bus.RS2_DATA);
      5'b01111: w_br  = bus.RS1_DATA < bus.RS2_DATA;
      5'b10000: w_br  = bus.RS1_DATA >= bus.RS2_DATA;
      5'b10001: w_alu = w_b;
      5'b10010: begin
        w_alu = bus.PC_IN + 32'd4;
        w_br  = 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd  <= '0;
      r_alu <= '0;
      r_br  <= 1'b0;
      r_ld  <= '0;
      r_st  <= '0;
      r_sd  <= '0;
      r_wb  <= 1'b0;
      r_we  <= 1'b0;
    end else if (!bus.STALL_EXECUTION_STAGE) begin
      r_rd  <= bus.RD_ADDRESS_IN;
      r_alu <= w_alu;
      r_br  <= w_br;
      r_ld  <= bus.DATA_CACHE_LOAD_IN;
      r_st  <= bus.DATA_CACHE_STORE_IN;
      r_sd  <= bus.DATA_CACHE_STORE_DATA_IN;
      r_wb  <= bus.WRITE_BACK_MUX_SELECT_IN;
      r_we  <= bus.RD_WRITE_ENABLE_IN;
    end
  end
  assign bus.RD_ADDRESS_OUT            = r_rd;
  assign bus.ALU_OUT                   = r_alu;
  assign bus.BRANCH_TAKEN              = r_br;
  assign bus.DATA_CACHE_LOAD_OUT       = r_ld;
  assign bus.DATA_CACHE_STORE_OUT      = r_st;
  assign bus.DATA_CACHE_STORE_DATA_OUT = r_sd;
  assign bus.WRITE_BACK_MUX_SELECT_OUT = r_wb;
  assign bus.RD_WRITE_ENABLE_OUT       = r_we;
endmodule

// File: tb/tb_execution_stage.sv
// tb_execution_stage: directed + randomized checks of execution_stage against an opcode-level model
module tb_execution_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [31:0] e_alu, e_sd;
  logic [4:0]  e_rd;
  logic [2:0]  e_ld;
  logic [1:0]  e_st;
  logic        e_br, e_wb, e_we;
  execution_stage_if bus ();
  execution_stage dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  // result of one instruction, written straight from the opcode table: {taken, alu_out}
  function automatic logic [32:0] model(input logic [4:0] op, input logic [31:0] pc, rs1, rs2,
                                        imm, input logic s1, s2);
    logic [31:0] a, b;
    int sh, ia, ib, i1, i2;
    a = s1 ? pc : rs1;
    b = s2 ? imm : rs2;
    sh = int'(b % 32);
    ia = a; ib = b; i1 = rs1; i2 = rs2;
    case (op)
      1:  return {1'b0, a + b};
      2:  return {1'b0, a - b};
      3:  return {1'b0, a * (32'd1 << sh)};
      4:  return {1'b0, (ia < ib) ? 32'd1 : 32'd0};
      5:  return {1'b0, (a < b) ? 32'd1 : 32'd0};
      6:  return {1'b0, a ^ b};
      7:  return {1'b0, a / (32'd1 << sh)};
      8:  return {1'b0, 32'(ia >>> sh)};
      9:  return {1'b0, a | b};
      10: return {1'b0, a & b};
      11: return {rs1 == rs2, 32'd0};
      12: return {rs1 != rs2, 32'd0};
      13: return {i1 < i2, 32'd0};
      14: return {i1 >= i2, 32'd0};
      15: return {rs1 < rs2, 32'd0};
      16: return {rs1 >= rs2, 32'd0};
      17: return {1'b0, b};
      18: return {1'b1, pc + 32'd4};
      default: return 33'd0;
    endcase
  endfunction
  task automatic compare_all(input string tag);
    chk({tag, ".alu"}, bus.ALU_OUT, e_alu);
    chk({tag, ".br"},  32'(bus.BRANCH_TAKEN), 32'(e_br));
    chk({tag, ".rd"},  32'(bus.RD_ADDRESS_OUT), 32'(e_rd));
    chk({tag, ".ld"},  32'(bus.DATA_CACHE_LOAD_OUT), 32'(e_ld));
    chk({tag, ".st"},  32'(bus.DATA_CACHE_STORE_OUT), 32'(e_st));
    chk({tag, ".sd"},  bus.DATA_CACHE_STORE_DATA_OUT, e_sd);
    chk({tag, ".wb"},  32'(bus.WRITE_BACK_MUX_SELECT_OUT), 32'(e_wb));
    chk({tag, ".we"},  32'(bus.RD_WRITE_ENABLE_OUT), 32'(e_we));
  endtask
  task automatic clear_exp();
    {e_alu, e_br, e_rd, e_ld, e_st, e_sd, e_wb, e_we} = '0;
  endtask
  task automatic step(input string tag, input logic stall);
    bus.STALL_EXECUTION_STAGE = stall;
    if (rst) clear_exp();
    else if (!stall) begin
      {e_br, e_alu} = model(bus.ALU_INSTRUCTION, bus.PC_IN, bus.RS1_DATA, bus.RS2_DATA,
                            bus.IMM_DATA, bus.ALU_INPUT_1_SELECT, bus.ALU_INPUT_2_SELECT);
      e_rd = bus.RD_ADDRESS_IN;
      e_ld = bus.DATA_CACHE_LOAD_IN;
      e_st = bus.DATA_CACHE_STORE_IN;
      e_sd = bus.DATA_CACHE_STORE_DATA_IN;
      e_wb = bus.WRITE_BACK_MUX_SELECT_IN;
      e_we = bus.RD_WRITE_ENABLE_IN;
    end
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask
  task automatic op_chk(input string tag, input logic [4:0] op, input logic [31:0] pc, rs1, rs2,
                        imm, input logic s1, s2, input logic [31:0] x_alu, input logic x_br);
    bus.ALU_INSTRUCTION = op;
    bus.PC_IN = pc; bus.RS1_DATA = rs1; bus.RS2_DATA = rs2; bus.IMM_DATA = imm;
    bus.ALU_INPUT_1_SELECT = s1; bus.ALU_INPUT_2_SELECT = s2;
    step(tag, 1'b0);
    chk({tag, ".k_alu"}, bus.ALU_OUT, x_alu);
    chk({tag, ".k_br"}, 32'(bus.BRANCH_TAKEN), 32'(x_br));
  endtask
  task automatic randomize_inputs();
    bus.PC_IN = $urandom; bus.RD_ADDRESS_IN = 5'($urandom);
    bus.RS1_DATA = $urandom;
    bus.RS2_DATA = ($urandom_range(0, 3) == 0) ? bus.RS1_DATA : $urandom;
    bus.IMM_DATA = $urandom; bus.ALU_INSTRUCTION = 5'($urandom_range(0, 31));
    bus.ALU_INPUT_1_SELECT = 1'($urandom); bus.ALU_INPUT_2_SELECT = 1'($urandom);
    bus.DATA_CACHE_LOAD_IN = 3'($urandom); bus.DATA_CACHE_STORE_IN = 2'($urandom);
    bus.DATA_CACHE_STORE_DATA_IN = $urandom;
    bus.WRITE_BACK_MUX_SELECT_IN = 1'($urandom); bus.RD_WRITE_ENABLE_IN = 1'($urandom);
  endtask
  initial begin
    randomize_inputs();
    bus.STALL_EXECUTION_STAGE = 1'b0;
    #1;
    clear_exp();
    compare_all("rst0");
    step("rst_clk", 1'b0);
    #3 rst = 1'b0;
    {bus.RD_ADDRESS_IN, bus.DATA_CACHE_LOAD_IN, bus.DATA_CACHE_STORE_IN} = '0;
    {bus.DATA_CACHE_STORE_DATA_IN, bus.WRITE_BACK_MUX_SELECT_IN, bus.RD_WRITE_ENABLE_IN} = '0;
    op_chk("add",    5'b00001, 0, 32'd2, 32'd1, 0, 0, 0, 32'd3, 0);
    op_chk("addwrap",5'b00001, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'd0, 0);
    op_chk("addsel", 5'b00001, 32'h100, 0, 0, 32'h20, 1, 1, 32'h120, 0);
    op_chk("sra",    5'b01000, 0, 32'h80000000, 0, 32'd4, 0, 1, 32'hF8000000, 0);
    op_chk("srl",    5'b00111, 0, 32'h80000000, 0, 32'd4, 0, 1, 32'h08000000, 0);
    op_chk("slt",    5'b00100, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'd1, 0);
    op_chk("sltu",   5'b00101, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'd0, 0);
    op_chk("blt",    5'b01101, 0, 32'hFFFFFFFF, 32'd1, 0, 1, 1, 32'd0, 1);
    op_chk("bltu",   5'b01111, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'd0, 0);
    op_chk("bgeu",   5'b10000, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'd0, 1);
    op_chk("bne",    5'b01100, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'd0, 1);
    op_chk("beq",    5'b01011, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'd0, 0);
    op_chk("bge",    5'b01110, 0, 32'd5, 32'd5, 0, 0, 0, 32'd0, 1);
    op_chk("jump",   5'b10010, 32'h40, 32'd9, 32'd9, 32'd7, 0, 0, 32'h44, 1);
    op_chk("passb",  5'b10001, 0, 0, 0, 32'h12345000, 0, 1, 32'h12345000, 0);
    op_chk("undef",  5'b10111, 32'h40, 32'd9, 32'd3, 32'd7, 0, 0, 32'd0, 0);
    bus.RD_ADDRESS_IN = 5'd5; bus.DATA_CACHE_LOAD_IN = 3'b010; bus.DATA_CACHE_STORE_IN = 2'b01;
    bus.DATA_CACHE_STORE_DATA_IN = 32'hDEADBEEF;
    bus.WRITE_BACK_MUX_SELECT_IN = 1'b1; bus.RD_WRITE_ENABLE_IN = 1'b1;
    step("pass", 1'b0);
    chk("pass.k_rd", 32'(bus.RD_ADDRESS_OUT), 32'd5);
    chk("pass.k_sd", bus.DATA_CACHE_STORE_DATA_OUT, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      step("stall", 1'b1);
    end
    chk("stall.k_sd", bus.DATA_CACHE_STORE_DATA_OUT, 32'hDEADBEEF);
    step("unstall", 1'b0);
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      step("rand", ($urandom_range(0, 4) == 0));
    end
    #3 rst = 1'b1;
    #1;
    clear_exp();
    compare_all("rst_async");
    step("rst_stall", 1'b1);
    step("rst_hold", 1'b0);
    #3 rst = 1'b0;
    randomize_inputs();
    step("post_rst", 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
